// File: rtl/multiplication_modulo_pkg.sv
// Shared constants for the serial modular multiplier: default operand
// width and the controller state encoding.
package multiplication_modulo_pkg;

    localparam int SIZE_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUL    = 2'd1,
        ST_REDUCE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/multiplication_modulo_reduce.sv
// Bit-serial restoring remainder: one dividend bit per cycle, W cycles.
// A one-cycle i_start pulse loads the operands; o_done pulses on the edge
// that completes the last step. A zero divisor reports a zero remainder.
module mod_reduce_serial #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_done,
    output logic [W-1:0] o_remainder
);

    localparam int CW = $clog2(W) + 1;

    // One extra bit so the shifted partial remainder never overflows
    logic [W:0]    r_rem;
    logic [W-1:0]  r_div;
    logic [W-1:0]  r_mod;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    logic [W:0]    w_shift;
    logic          w_ge;
    logic [W:0]    w_trial;

    // The previous remainder is always below the divisor, so its top bit is zero
    assign w_shift = {r_rem[W-1:0], r_div[W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_mod});
    assign w_trial = w_ge ? (w_shift - {1'b0, r_mod}) : w_shift;

    // Load on start, then shift in one dividend MSB per cycle and restore
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_mod  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= '0;
                r_div  <= i_dividend;
                r_mod  <= i_divisor;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_trial;
                r_div <= {r_div[W-2:0], 1'b0};
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CW'(W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done      = r_done;
    assign o_remainder = (r_mod == '0) ? '0 : r_rem[W-1:0];

endmodule

// File: rtl/multiplication_modulo.sv
// Serial (A*B) mod M: SIZE-cycle shift-add multiply, then a 2*SIZE-cycle
// restoring reduction, with a joint three-input accept and held output.
module multiplication_modulo
    import multiplication_modulo_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SIZE-1:0]   input_multiplier_tdata,
    input  logic              input_multiplier_tvalid,
    output logic              input_multiplier_tready,
    input  logic [SIZE-1:0]   input_multiplicand_tdata,
    input  logic              input_multiplicand_tvalid,
    output logic              input_multiplicand_tready,
    input  logic [2*SIZE-1:0] input_modulus_tdata,
    input  logic              input_modulus_tvalid,
    output logic              input_modulus_tready,
    output logic [2*SIZE-1:0] output_tdata,
    output logic              output_tvalid,
    input  logic              output_tready
);

    localparam int PW = 2 * SIZE;
    localparam int CW = $clog2(SIZE) + 1;

    state_t          r_state;
    logic [SIZE-1:0] r_a;
    logic [PW-1:0]   r_b_sh;
    logic [PW-1:0]   r_prod;
    logic [PW-1:0]   r_m;
    logic [PW-1:0]   r_tdata;
    logic [CW-1:0]   r_cnt;
    logic            r_tready;
    logic            r_tvalid;

    logic            w_accept;
    logic [PW-1:0]   w_prod_next;
    logic            w_mul_last;
    logic            w_red_done;
    logic [PW-1:0]   w_red_rem;

    // r_tready is only high in IDLE, so it also gates acceptance after reset release
    assign w_accept = (r_state == ST_IDLE) && r_tready && input_multiplier_tvalid
                    && input_multiplicand_tvalid && input_modulus_tvalid;

    // LSB-first shift-add: the multiplicand walks left as the multiplier walks right
    assign w_prod_next = r_prod + (r_a[0] ? r_b_sh : '0);
    assign w_mul_last  = (r_state == ST_MUL) && (r_cnt == CW'(SIZE - 1));

    // The final product is handed over combinationally on the last MUL edge
    mod_reduce_serial #(
        .W (PW)
    ) u_reduce (
        .clk         (clk),
        .rst_n       (rst),
        .i_start     (w_mul_last),
        .i_dividend  (w_prod_next),
        .i_divisor   (r_m),
        .o_done      (w_red_done),
        .o_remainder (w_red_rem)
    );

    // Controller with registered handshake outputs and the inline multiply datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b_sh   <= '0;
            r_prod   <= '0;
            r_m      <= '0;
            r_tdata  <= '0;
            r_cnt    <= '0;
            r_tready <= 1'b0;
            r_tvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a      <= input_multiplier_tdata;
                        r_b_sh   <= PW'(input_multiplicand_tdata);
                        r_m      <= input_modulus_tdata;
                        r_prod   <= '0;
                        r_cnt    <= '0;
                        r_tready <= 1'b0;
                        r_state  <= ST_MUL;
                    end else begin
                        r_tready <= 1'b1;
                    end
                end
                ST_MUL: begin
                    r_prod <= w_prod_next;
                    r_a    <= r_a >> 1;
                    r_b_sh <= r_b_sh << 1;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_state <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    if (w_red_done) begin
                        r_tdata  <= w_red_rem;
                        r_tvalid <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (output_tready) begin
                        r_tvalid <= 1'b0;
                        r_tready <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign input_multiplier_tready   = r_tready;
    assign input_multiplicand_tready = r_tready;
    assign input_modulus_tready      = r_tready;
    assign output_tdata              = r_tdata;
    assign output_tvalid             = r_tvalid;

endmodule

// File: tb/tb_multiplication_modulo.sv
// Directed bench for multiplication_modulo with SIZE=64.
module tb_multiplication_modulo;

    logic         clk;
    logic         rst;
    logic [63:0]  a_tdata;
    logic         a_tvalid;
    logic         a_tready;
    logic [63:0]  b_tdata;
    logic         b_tvalid;
    logic         b_tready;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic [127:0] o_tdata;
    logic         o_tvalid;
    logic         o_tready;

    int n_vec = 0;
    int n_err = 0;

    multiplication_modulo #(
        .SIZE (64)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .input_multiplier_tdata    (a_tdata),
        .input_multiplier_tvalid   (a_tvalid),
        .input_multiplier_tready   (a_tready),
        .input_multiplicand_tdata  (b_tdata),
        .input_multiplicand_tvalid (b_tvalid),
        .input_multiplicand_tready (b_tready),
        .input_modulus_tdata       (m_tdata),
        .input_modulus_tvalid      (m_tvalid),
        .input_modulus_tready      (m_tready),
        .output_tdata              (o_tdata),
        .output_tvalid             (o_tvalid),
        .output_tready             (o_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input logic [2:0] v);
        a_tvalid = v[2];
        b_tvalid = v[1];
        m_tvalid = v[0];
    endtask

    // Apply one operation; hold > 0 keeps output_tready low for that many cycles of valid
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] m, input logic [127:0] exp, input int hold);
        int cnt;
        o_tready = (hold == 0);
        for (int w = 0; w < 20 && !a_tready; w++) begin
            @(posedge clk);
            #1;
        end
        check({tag, " tready before accept"}, {a_tready, b_tready, m_tready}, 3'b111);
        a_tdata = a;
        b_tdata = b;
        m_tdata = m;
        set_valid(3'b111);
        @(posedge clk);
        #1;
        check({tag, " tready after accept"}, {a_tready, b_tready, m_tready}, 3'b000);
        set_valid(3'b000);
        a_tdata = ~a;
        b_tdata = b ^ 64'h5A5A_0000_1234_FFFF;
        m_tdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!o_tvalid && cnt < 400);
        check({tag, " latency"}, cnt, 193);
        check({tag, " result"}, o_tdata, exp);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check({tag, " held"}, {o_tvalid, o_tdata}, {1'b1, exp});
            end
            o_tready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, " after handshake"}, {o_tvalid, a_tready, b_tready, m_tready, o_tdata},
              {4'b0111, exp});
    endtask

    initial begin
        int cnt;
        logic ok;
        rst      = 1'b0;
        a_tdata  = '0;
        b_tdata  = '0;
        m_tdata  = '0;
        set_valid(3'b000);
        o_tready = 1'b0;
        #5 o_tready = 1'b1;

        // Reset values, and tready rising on the first edge after release
        #7;
        check("reset outputs", {o_tvalid, a_tready, b_tready, m_tready, o_tdata}, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("tready before first edge", {a_tready, b_tready, m_tready}, 3'b000);
        @(posedge clk);
        #1;
        check("tready after release", {a_tready, b_tready, m_tready}, 3'b111);

        run_op("req021", 64'd143563561627, 64'd21376213, 128'd69814, 128'd25103, 0);
        run_op("req022", 64'd7, 64'd9, 128'd5, 128'd3, 10);
        run_op("max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
               128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 0);
        run_op("mod2^64", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               128'h1_0000_0000_0000_0000, 128'd1, 0);
        run_op("m0", 64'd143563561627, 64'd21376213, 128'd0, 128'd0, 0);
        run_op("m1", 64'd143563561627, 64'd21376213, 128'd1, 128'd0, 0);
        run_op("a0", 64'd0, 64'd21376213, 128'd69814, 128'd0, 0);
        run_op("b0", 64'd143563561627, 64'd0, 128'd69814, 128'd0, 0);

        // Partial valid must neither drop tready nor start an operation
        a_tdata = 64'd3;
        b_tdata = 64'd4;
        m_tdata = 128'd5;
        ok = 1'b1;
        for (int p = 0; p < 3; p++) begin
            set_valid(3'b111 ^ (3'b001 << p));
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1;
                if ({a_tready, b_tready, m_tready, o_tvalid} !== 4'b1110) ok = 1'b0;
            end
        end
        set_valid(3'b000);
        check("partial valid ignored", ok, 1'b1);
        run_op("after partial", 64'd12, 64'd11, 128'd7, 128'd6, 0);

        // Back-to-back with valid held: second op accepted on the first IDLE edge
        o_tready = 1'b1;
        a_tdata  = 64'd12;
        b_tdata  = 64'd11;
        m_tdata  = 128'd7;
        set_valid(3'b111);
        @(posedge clk);
        #1;
        check("b2b first accept", {a_tready, b_tready, m_tready}, 3'b000);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!o_tvalid && cnt < 400);
        check("b2b first latency", cnt, 193);
        check("b2b first result", o_tdata, 128'd6);
        @(posedge clk);
        #1;
        check("b2b idle cycle", {o_tvalid, a_tready}, 2'b01);
        a_tdata = 64'd1000;
        b_tdata = 64'd1000;
        m_tdata = 128'd999999;
        @(posedge clk);
        #1;
        check("b2b second accept", {a_tready, b_tready, m_tready}, 3'b000);
        set_valid(3'b000);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!o_tvalid && cnt < 400);
        check("b2b second latency", cnt, 193);
        check("b2b second result", o_tdata, 128'd1);
        @(posedge clk);
        #1;

        // Reset during MUL aborts with no output
        a_tdata = 64'd7;
        b_tdata = 64'd9;
        m_tdata = 128'd5;
        set_valid(3'b111);
        @(posedge clk);
        #1;
        set_valid(3'b000);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid-op reset outputs", {o_tvalid, a_tready, b_tready, m_tready, o_tdata}, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid-op tready before edge", {a_tready, b_tready, m_tready}, 3'b000);
        @(posedge clk);
        #1;
        check("mid-op tready after edge", {a_tready, b_tready, m_tready}, 3'b111);
        ok = 1'b1;
        for (int i = 0; i < 250; i++) begin
            @(posedge clk);
            #1;
            if (o_tvalid !== 1'b0) ok = 1'b0;
        end
        check("no output after abort", ok, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multiplication_modulo.md
MULTIPLICATION_MODULO -- requirements
Module: multiplication_modulo

Interface
REQ-001 SHALL have parameter SIZE, default 64, operand width in bits; modulus, product and result are 2*SIZE bits.
REQ-002 SHALL have the following ports, listed as name  direction  width  meaning:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- input_multiplier_tdata  in  SIZE  multiplier A.
- input_multiplier_tvalid  in  1  A valid.
- input_multiplier_tready  out  1  A accepted when high with tvalid.
- input_multiplicand_tdata  in  SIZE  multiplicand B.
- input_multiplicand_tvalid  in  1  B valid.
- input_multiplicand_tready  out  1  B ready.
- input_modulus_tdata  in  2*SIZE  modulus M.
- input_modulus_tvalid  in  1  M valid.
- input_modulus_tready  out  1  M ready.
- output_tdata  out  2*SIZE  result (A*B) mod M.
- output_tvalid  out  1  result valid.
- output_tready  in  1  downstream ready.

Function
REQ-003 SHALL compute R = (A*B) mod M exactly, unsigned, full 2*SIZE-bit product with no truncation.
REQ-004 SHALL implement states IDLE, MUL, REDUCE, DONE.
REQ-005 In IDLE, all three input tready outputs SHALL be high; in every other state they SHALL be low.
REQ-006 Inputs SHALL be accepted jointly only on an edge where the state is IDLE and all three tvalid are high; partial valid SHALL NOT capture anything; the accept edge registers A, B and M and moves to MUL.
REQ-007 MUL SHALL last exactly SIZE cycles, one shift-add step per multiplier bit, producing the 2*SIZE-bit product P.
REQ-008 REDUCE SHALL last exactly 2*SIZE cycles of restoring remainder: r = (r<<1)|next MSB of P; if r >= M then r = r - M. The remainder register SHALL be 2*SIZE+1 bits wide to avoid overflow.
REQ-009 After REDUCE, the state SHALL go to DONE; output_tvalid SHALL be high exactly 3*SIZE+1 rising edges after the accept edge.
REQ-010 In DONE, output_tdata and output_tvalid SHALL be held stable until a rising edge where output_tready is high; that edge SHALL return the state to IDLE and clear output_tvalid.
REQ-011 output_tvalid SHALL be low in every state except DONE; output_tdata SHALL keep the last result outside DONE.
REQ-012 Back-to-back operation: with tvalid held high, a new operation SHALL be accepted on the first IDLE edge after the result is consumed (one IDLE cycle minimum).
REQ-013 M = 0 SHALL yield R = 0; M = 1 SHALL yield R = 0; A = 0 or B = 0 SHALL yield R = 0; timing SHALL NOT depend on operand values.
REQ-014 Input tdata changes outside the accept edge SHALL have no effect on an operation in progress.

Reset
REQ-015 While rst is low, the state SHALL be IDLE and all internal registers SHALL be cleared.
REQ-016 While rst is low, the outputs SHALL be: output_tvalid = 0, output_tdata = 0, and all input tready = 0.
REQ-017 The input tready outputs SHALL rise on the first rising edge after rst deasserts.
REQ-018 Reset asserted mid-operation SHALL abort the operation immediately with no output produced.

Structure
REQ-019 A shared package SHALL hold the SIZE default and the state encoding constants.
REQ-020 The REDUCE datapath SHALL be a sub-module mod_reduce_serial (2*SIZE-bit dividend, 2*SIZE-bit divisor, start/done signals); the multiply datapath SHALL be inline.

Verification
REQ-021 A=143563561627, B=21376213, M=69814, all valid, output_tready low for the first 5 ns then high -> output_tdata = 25103, with output_tvalid asserted 193 edges after the accept edge (SIZE=64).
REQ-022 A=7, B=9, M=5 with output_tready held low for 10 cycles after valid -> output_tdata = 3 held stable with tvalid high throughout, then IDLE after the handshake.
REQ-023 A=2^64-1, B=2^64-1, M=2^128-1 -> R = (2^64-1)^2 = 0xFFFFFFFFFFFFFFFE0000000000000001.
REQ-024 M=0 -> R=0; M=1 -> R=0; A=0 -> R=0; timing identical to REQ-021.
REQ-025 Only two of the three tvalid high -> no tready drop and no capture; rst pulsed low during MUL -> tvalid stays 0 and tready returns one edge after release.
